rca_multiword_add_ctrl: RTL and testbench

//  Multi-cycle sequencer for wide additions on one shared ripple_carry_adder_16.

---
 rtl/rca_multiword_add_ctrl_pkg.sv | 17 +
 rtl/ripple_carry_adder_16.sv | 23 ++
 rtl/rca_multiword_add_ctrl.sv | 106 ++++++++++
 tb/tb_rca_multiword_add_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rca_multiword_add_ctrl_pkg.sv
// Shared definitions for the multi-word ripple-carry add sequencer.
// Slice width, FSM state encoding and index-width helper.
package rca_multiword_add_ctrl_pkg;

    localparam int CHUNK_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int idx_w(input int chunks);
        return (chunks > 1) ? $clog2(chunks) : 1;
    endfunction

endpackage

// File: rtl/ripple_carry_adder_16.sv
// 16-bit combinational ripple-carry adder.
// Shared by the multi-word sequencer, one slice per clock.
module ripple_carry_adder_16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic c;

    always_comb begin
        sum = '0;
        c   = cin;
        for (int i = 0; i < 16; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/rca_multiword_add_ctrl.sv
// Wide adder sequencer: one 16-bit slice per clock, LSB first,
// on a single shared ripple-carry adder, with valid/ready on both sides.
module rca_multiword_add_ctrl
    import rca_multiword_add_ctrl_pkg::*;
#(
    parameter  int CHUNKS = 4,
    localparam int W      = CHUNK_W * CHUNKS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         busy
);

    localparam int IDX_W = idx_w(CHUNKS);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(CHUNKS - 1);

    state_t state_q, state_d;

    logic [IDX_W-1:0]   idx_q;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic [W-1:0]       sum_q;
    logic               carry_q;
    logic               cout_q;
    logic               accept;

    logic [CHUNK_W-1:0] a_sl;
    logic [CHUNK_W-1:0] b_sl;
    logic [CHUNK_W-1:0] s_sl;
    logic               c_sl;

    assign accept    = in_valid && (state_q == ST_IDLE);
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;

    assign a_sl = a_q[idx_q * CHUNK_W +: CHUNK_W];
    assign b_sl = b_q[idx_q * CHUNK_W +: CHUNK_W];

    ripple_carry_adder_16 u_adder (
        .a    (a_sl),
        .b    (b_sl),
        .cin  (carry_q),
        .sum  (s_sl),
        .cout (c_sl)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept)         state_d = ST_RUN;
            ST_RUN:  if (idx_q == LAST)  state_d = ST_DONE;
            ST_DONE: if (out_ready)      state_d = ST_IDLE;
            default:                     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            if (accept) begin
                a_q     <= a;
                b_q     <= b;
                carry_q <= cin;
                idx_q   <= '0;
            end
            if (state_q == ST_RUN) begin
                sum_q[idx_q * CHUNK_W +: CHUNK_W] <= s_sl;
                carry_q <= c_sl;
                // Wrap to 0 so the slice mux never points past the operand
                if (idx_q == LAST) begin
                    idx_q  <= '0;
                    cout_q <= c_sl;
                end else begin
                    idx_q <= idx_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rca_multiword_add_ctrl.sv
// Bench for the wide-add sequencer at CHUNKS = 1, 3 and 4.
// Scoreboard of expected {cout,sum} filled at accept, drained at output.
module tb_rca_multiword_add_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        in_valid  [3];
    logic        cin       [3];
    logic        out_ready [3];
    logic [63:0] a         [3];
    logic [63:0] b         [3];
    wire         in_ready  [3];
    wire         out_valid [3];
    wire         cout      [3];
    wire         busy      [3];
    wire  [63:0] sum_w     [3];

    logic [15:0] sum1;
    logic [47:0] sum3;
    logic [63:0] sum4;
    assign sum_w[0] = {48'd0, sum1};
    assign sum_w[1] = {16'd0, sum3};
    assign sum_w[2] = sum4;

    logic [64:0] sb[$];

    rca_multiword_add_ctrl #(.CHUNKS(1)) u_c1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a[0][15:0]), .b(b[0][15:0]), .cin(cin[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .sum(sum1), .cout(cout[0]), .busy(busy[0])
    );

    rca_multiword_add_ctrl #(.CHUNKS(3)) u_c3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a[1][47:0]), .b(b[1][47:0]), .cin(cin[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .sum(sum3), .cout(cout[1]), .busy(busy[1])
    );

    rca_multiword_add_ctrl #(.CHUNKS(4)) u_c4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .a(a[2]), .b(b[2]), .cin(cin[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .sum(sum4), .cout(cout[2]), .busy(busy[2])
    );

    function automatic int nch(input int k);
        case (k)
            0:       return 1;
            1:       return 3;
            default: return 4;
        endcase
    endfunction

    function automatic logic [63:0] mask(input int k);
        if (nch(k) == 4) return '1;
        return (64'd1 << (16 * nch(k))) - 64'd1;
    endfunction

    task automatic send(input int k, input logic [63:0] av,
                        input logic [63:0] bv, input logic cv,
                        output int acc);
        logic [63:0] m;
        logic [64:0] t;
        int w;
        int guard;
        m = mask(k);
        w = 16 * nch(k);
        guard = 0;
        @(negedge clk);
        a[k] = av;
        b[k] = bv;
        cin[k] = cv;
        in_valid[k] = 1'b1;
        while (!in_ready[k] && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready[k]) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout dut=%0d in_ready=%b required=1", k, in_ready[k]);
        end
        acc = cyc + 1;
        t = {1'b0, av & m} + {1'b0, bv & m} + {64'd0, cv};
        sb.push_back({t[w], t[63:0] & m});
        @(negedge clk);
        in_valid[k] = 1'b0;
        a[k] = {$urandom, $urandom};
        b[k] = {$urandom, $urandom};
        cin[k] = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_out(input int k, input int acc, output int lat);
        int guard;
        guard = 0;
        while (!out_valid[k] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!out_valid[k]) begin
            checks++;
            failures++;
            $display("FAIL out_timeout dut=%0d out_valid=%b required=1", k, out_valid[k]);
        end
        lat = cyc - acc;
    endtask

    task automatic take(input int k);
        out_ready[k] = 1'b1;
        @(negedge clk);
        out_ready[k] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({in_ready[k], out_valid[k], busy[k]} !== 3'b100) begin
                failures++;
                $display("FAIL reset_flags dut=%0d got=%b required=100",
                         k, {in_ready[k], out_valid[k], busy[k]});
            end
            checks++;
            if ({cout[k], sum_w[k]} !== 65'd0) begin
                failures++;
                $display("FAIL reset_sum dut=%0d got=%h required=0",
                         k, {cout[k], sum_w[k]});
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic directed(input int k, input string name,
                            input logic [63:0] av, input logic [63:0] bv,
                            input logic cv, input logic [64:0] req);
        int acc;
        int lat;
        logic [64:0] e;
        send(k, av, bv, cv, acc);
        wait_out(k, acc, lat);
        e = sb.pop_front();
        checks++;
        if ({cout[k], sum_w[k]} !== req) begin
            failures++;
            $display("FAIL %s_result got=%h required=%h", name, {cout[k], sum_w[k]}, req);
        end
        checks++;
        if (e !== req) begin
            failures++;
            $display("FAIL %s_model got=%h required=%h", name, e, req);
        end
        checks++;
        if (lat != nch(k)) begin
            failures++;
            $display("FAIL %s_latency got=%0d required=%0d", name, lat, nch(k));
        end
        take(k);
    endtask

    task automatic test_carry_wrap();
        directed(2, "wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, {1'b1, 64'h0});
    endtask

    task automatic test_slice_carry();
        directed(2, "slice", 64'h0000_0000_0000_FFFF, 64'h0, 1'b1,
                 {1'b0, 64'h0000_0000_0001_0000});
    endtask

    task automatic test_all_ones();
        directed(2, "ones", '1, '1, 1'b1, {1'b1, 64'hFFFF_FFFF_FFFF_FFFF});
    endtask

    task automatic test_chunks1();
        directed(0, "c1", 64'hFFFF, 64'h1, 1'b0, {1'b1, 64'h0});
    endtask

    task automatic test_backpressure();
        int acc;
        int lat;
        logic [64:0] req;
        req = {1'b0, 64'h1234_5678_9ABC_DEF0} + {1'b0, 64'h0FED_CBA9_8765_4321};
        send(2, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, acc);
        wait_out(2, acc, lat);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (!out_valid[2] || {cout[2], sum_w[2]} !== req || in_ready[2]) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d valid=%b ready=%b got=%h required=%h",
                         i, out_valid[2], in_ready[2], {cout[2], sum_w[2]}, req);
            end
            in_valid[2] = (i == 2);
            a[2] = 64'h5;
            b[2] = 64'h7;
            @(negedge clk);
        end
        in_valid[2] = 1'b0;
        void'(sb.pop_front());
        checks++;
        if ({cout[2], sum_w[2]} !== req) begin
            failures++;
            $display("FAIL bp_result got=%h required=%h", {cout[2], sum_w[2]}, req);
        end
        take(2);
        repeat (6) @(negedge clk);
        checks++;
        if (out_valid[2] || busy[2]) begin
            failures++;
            $display("FAIL bp_no_capture valid=%b busy=%b required=0/0",
                     out_valid[2], busy[2]);
        end
    endtask

    task automatic test_reset_mid_run();
        int acc;
        send(2, 64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_2222_3333_4444, 1'b1, acc);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid[2] || busy[2] || !in_ready[2]) begin
            failures++;
            $display("FAIL abort_flags valid=%b busy=%b ready=%b required=0/0/1",
                     out_valid[2], busy[2], in_ready[2]);
        end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        directed(2, "after_abort", 64'h1234, 64'h1, 1'b0, {1'b0, 64'h1235});
    endtask

    task automatic test_random(input int k, input int n);
        fork
            begin
                int acc;
                for (int i = 0; i < n; i++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    send(k, {$urandom, $urandom}, {$urandom, $urandom},
                         1'($urandom_range(0, 1)), acc);
                end
            end
            begin
                int got;
                int idle;
                logic [64:0] e;
                got = 0;
                idle = 0;
                while (got < n && idle < 2000) begin
                    @(negedge clk);
                    out_ready[k] = 1'($urandom_range(0, 1));
                    if (out_valid[k]) begin
                        idle = 0;
                        checks++;
                        if (sb.size() == 0) begin
                            failures++;
                            $display("FAIL rnd_unexpected dut=%0d got=%h required=none",
                                     k, {cout[k], sum_w[k]});
                        end else begin
                            e = sb[0];
                            if ({cout[k], sum_w[k]} !== e) begin
                                failures++;
                                $display("FAIL rnd_result dut=%0d op=%0d got=%h required=%h",
                                         k, got, {cout[k], sum_w[k]}, e);
                            end
                            if (out_ready[k]) begin
                                void'(sb.pop_front());
                                got++;
                            end
                        end
                    end else begin
                        idle++;
                    end
                end
                checks++;
                if (got != n) begin
                    failures++;
                    $display("FAIL rnd_count dut=%0d got=%0d required=%0d", k, got, n);
                end
            end
        join
        @(negedge clk);
        out_ready[k] = 1'b0;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL rnd_drain dut=%0d left=%0d required=0", k, sb.size());
        end
        sb.delete();
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            in_valid[k] = 1'b0;
            cin[k] = 1'b0;
            out_ready[k] = 1'b0;
            a[k] = '0;
            b[k] = '0;
        end
        test_reset();
        test_carry_wrap();
        test_slice_carry();
        test_backpressure();
        test_reset_mid_run();
        test_all_ones();
        test_chunks1();
        test_random(2, 1000);
        test_random(1, 300);
        test_random(0, 300);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
